// File: rtl/sw_debounce_pkg.sv
// -----------------------------------------------------------------------------
// sw_pkg
// Shared constants and types for the switch-conditioning stage.
//   SW_WIDTH            - number of board slide switches
//   SW_DEBOUNCE_DEFAULT - debounce length for hardware (10 ms at 100 MHz)
//   SW_DEBOUNCE_SIM     - short debounce length for simulation
//   db_state_e          - per-bit debounce state, kept for debug visibility
// -----------------------------------------------------------------------------
package sw_pkg;

  localparam int SW_WIDTH            = 8;
  localparam int SW_DEBOUNCE_DEFAULT = 1_000_000;
  localparam int SW_DEBOUNCE_SIM     = 4;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    COUNTING = 2'd1,
    COMMIT   = 2'd2
  } db_state_e;

  // Counter width large enough to hold 0 .. cycles-1 (and cycles itself).
  function automatic int cntWidth(input int cycles);
    return $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/sw_debounce_if.sv
// -----------------------------------------------------------------------------
// sw_debounce_if
// Bundles the raw switch input with the conditioned outputs.
//   sw_in     - raw, asynchronous, bouncing switch levels
//   sw_stable - debounced switch levels
//   sw_rise   - one-cycle pulse per bit on a debounced 0->1
//   sw_fall   - one-cycle pulse per bit on a debounced 1->0
// Modports:
//   master - the side that supplies sw_in and consumes the conditioned outputs
//   slave  - the debouncer itself
// -----------------------------------------------------------------------------
interface sw_debounce_if
  import sw_pkg::*;
#(
  parameter int WIDTH = SW_WIDTH
);

  logic [WIDTH-1:0] sw_in;
  logic [WIDTH-1:0] sw_stable;
  logic [WIDTH-1:0] sw_rise;
  logic [WIDTH-1:0] sw_fall;

  modport master (
    output sw_in,
    input  sw_stable,
    input  sw_rise,
    input  sw_fall
  );

  modport slave (
    input  sw_in,
    output sw_stable,
    output sw_rise,
    output sw_fall
  );

endinterface

// File: rtl/sw_debounce_bit.sv
// -----------------------------------------------------------------------------
// debounce_bit
// Conditions a single switch bit: two-flop synchronizer, mismatch counter,
// stable flop and (optionally) registered edge pulses.
// Ports:
//   clk      - system clock, rising edge
//   rst      - asynchronous active-high reset
//   sw_i     - raw switch level
//   stable_o - debounced level
//   rise_o   - one-cycle pulse in the first cycle stable_o is 1 after 0
//   fall_o   - one-cycle pulse in the first cycle stable_o is 0 after 1
// Build option: SW_DEBOUNCE_EDGE_EN builds the edge-pulse registers; without
// it rise_o/fall_o are tied to 0 and stable_o is unaffected.
// -----------------------------------------------------------------------------
module debounce_bit
  import sw_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = SW_DEBOUNCE_DEFAULT,
  parameter int CNT_W           = cntWidth(DEBOUNCE_CYCLES)
) (
  input  logic clk,
  input  logic rst,
  input  logic sw_i,
  output logic stable_o,
  output logic rise_o,
  output logic fall_o
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             s1_q;
  logic             s2_q;
  logic             st_q;
  logic             st_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  db_state_e        state_w;

  // Classify this cycle. Any cycle where the synchronized input agrees with
  // the stable value is IDLE, which is what throws away a partial count when
  // the input bounces back.
  always_comb begin
    state_w = IDLE;
    if (s2_q != st_q) begin
      state_w = (cnt_q == LAST) ? COMMIT : COUNTING;
    end
  end

  // Next-state for the counter and stable flop. The counter never passes
  // LAST, so no wrap-around handling is needed.
  always_comb begin
    st_d  = st_q;
    cnt_d = '0;
    case (state_w)
      IDLE:     cnt_d = '0;
      COUNTING: cnt_d = cnt_q + CNT_W'(1);
      COMMIT: begin
        st_d  = s2_q;
        cnt_d = '0;
      end
      default:  cnt_d = '0;
    endcase
  end

  // Synchronizer, counter and stable flop. Only s2_q is used past the
  // synchronizer so metastability on s1_q never reaches the counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q  <= 1'b0;
      s2_q  <= 1'b0;
      st_q  <= 1'b0;
      cnt_q <= '0;
    end else begin
      s1_q  <= sw_i;
      s2_q  <= s1_q;
      st_q  <= st_d;
      cnt_q <= cnt_d;
    end
  end

  assign stable_o = st_q;

`ifdef SW_DEBOUNCE_EDGE_EN
  logic rise_q;
  logic fall_q;

  // The pulse is registered on the same edge that commits the new stable
  // value, so it lines up with the first cycle of the new level. Only one of
  // the two can be set because COMMIT carries a single direction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      rise_q <= (state_w == COMMIT) &&  s2_q;
      fall_q <= (state_w == COMMIT) && !s2_q;
    end
  end

  assign rise_o = rise_q;
  assign fall_o = fall_q;
`else
  assign rise_o = 1'b0;
  assign fall_o = 1'b0;
`endif

endmodule

// File: rtl/sw_debounce.sv
// -----------------------------------------------------------------------------
// sw_debounce
// Synchronizes and debounces the board slide switches, one independent
// debounce_bit per switch.
// Parameters:
//   WIDTH           - number of switch bits (must match the interface WIDTH)
//   DEBOUNCE_CYCLES - stable-mismatch cycles before an output bit changes,
//                     1 .. 2^24-1
// Ports:
//   clk - system clock, rising edge
//   rst - asynchronous active-high reset
//   bus - sw_debounce_if slave: sw_in in; sw_stable, sw_rise, sw_fall out
// Build option: SW_DEBOUNCE_EDGE_EN enables the sw_rise/sw_fall pulses;
// without it both are held at 0.
// -----------------------------------------------------------------------------
module sw_debounce
  import sw_pkg::*;
#(
  parameter int WIDTH           = SW_WIDTH,
  parameter int DEBOUNCE_CYCLES = SW_DEBOUNCE_DEFAULT
) (
  input  logic           clk,
  input  logic           rst,
  sw_debounce_if.slave   bus
);

  logic [WIDTH-1:0] stable_w;
  logic [WIDTH-1:0] rise_w;
  logic [WIDTH-1:0] fall_w;

  // One conditioner per switch; bits share nothing but the clock and reset.
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    debounce_bit #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_bit (
      .clk      (clk),
      .rst      (rst),
      .sw_i     (bus.sw_in[i]),
      .stable_o (stable_w[i]),
      .rise_o   (rise_w[i]),
      .fall_o   (fall_w[i])
    );
  end

  assign bus.sw_stable = stable_w;
  assign bus.sw_rise   = rise_w;
  assign bus.sw_fall   = fall_w;

endmodule

// File: tb/tb_sw_debounce.sv
// -----------------------------------------------------------------------------
// tb_sw_debounce
// Directed bench for sw_debounce. Main DUT uses DEBOUNCE_CYCLES = 4; a second
// instance with DEBOUNCE_CYCLES = 1 covers the shortest debounce length.
// Edge-pulse expectations are masked to 0 unless SW_DEBOUNCE_EDGE_EN is set.
// -----------------------------------------------------------------------------
module tb_sw_debounce;
  import sw_pkg::*;

  localparam int W = SW_WIDTH;

`ifdef SW_DEBOUNCE_EDGE_EN
  localparam logic [W-1:0] EDGE_MASK = '1;
`else
  localparam logic [W-1:0] EDGE_MASK = '0;
`endif

  logic         clk  = 1'b0;
  logic         rst  = 1'b0;
  logic [W-1:0] swIn = '0;

  int nCompared   = 0;
  int nMismatched = 0;

  // Free-running 10 ns clock, rising edges at 5, 15, 25, ...
  always #5 clk = ~clk;

  sw_debounce_if #(.WIDTH(W)) busA ();
  sw_debounce_if #(.WIDTH(W)) busB ();

  assign busA.sw_in = swIn;
  assign busB.sw_in = swIn;

  sw_debounce #(
    .WIDTH           (W),
    .DEBOUNCE_CYCLES (SW_DEBOUNCE_SIM)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (busA)
  );

  sw_debounce #(
    .WIDTH           (W),
    .DEBOUNCE_CYCLES (1)
  ) dutFast (
    .clk (clk),
    .rst (rst),
    .bus (busB)
  );

  typedef struct {
    logic [W-1:0] sw;
    logic [W-1:0] expStable;
    logic [W-1:0] expRise;
    logic [W-1:0] expFall;
  } vec_t;

  vec_t vecs [22];

  task automatic compareVal(input string name, input logic [W-1:0] act,
                            input logic [W-1:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatched++;
      $display("[TB] FAIL %s: got 0x%02h, expected 0x%02h", name, act, exp);
    end
  endtask

  task automatic checkOutput(input string tag, input logic [W-1:0] expStable,
                             input logic [W-1:0] expRise,
                             input logic [W-1:0] expFall);
    compareVal({tag, " sw_stable"}, busA.sw_stable, expStable);
    compareVal({tag, " sw_rise"},   busA.sw_rise,   expRise & EDGE_MASK);
    compareVal({tag, " sw_fall"},   busA.sw_fall,   expFall & EDGE_MASK);
  endtask

  task automatic checkFast(input string tag, input logic [W-1:0] expStable,
                           input logic [W-1:0] expRise,
                           input logic [W-1:0] expFall);
    compareVal({tag, " fast sw_stable"}, busB.sw_stable, expStable);
    compareVal({tag, " fast sw_rise"},   busB.sw_rise,   expRise & EDGE_MASK);
    compareVal({tag, " fast sw_fall"},   busB.sw_fall,   expFall & EDGE_MASK);
  endtask

  // Drive the switches, let one rising edge pass, sample 1 ns later.
  task automatic applyStimulus(input logic [W-1:0] sw);
    swIn = sw;
    @(posedge clk);
    #1;
  endtask

  // Hold reset across one edge, release it mid-cycle.
  task automatic releaseReset();
    @(posedge clk);
    #3;
    rst = 1'b0;
  endtask

  initial begin
    // Clean step 0x00 -> 0x05 (6 edges to commit), then 0x05 -> 0xFF
    // (bits 1,3..7 rise together), then 0xFF -> 0x0F (bits 4..7 fall).
    vecs[0]  = '{8'h05, 8'h00, 8'h00, 8'h00};
    vecs[1]  = '{8'h05, 8'h00, 8'h00, 8'h00};
    vecs[2]  = '{8'h05, 8'h00, 8'h00, 8'h00};
    vecs[3]  = '{8'h05, 8'h00, 8'h00, 8'h00};
    vecs[4]  = '{8'h05, 8'h00, 8'h00, 8'h00};
    vecs[5]  = '{8'h05, 8'h05, 8'h05, 8'h00};
    vecs[6]  = '{8'h05, 8'h05, 8'h00, 8'h00};
    vecs[7]  = '{8'h05, 8'h05, 8'h00, 8'h00};
    vecs[8]  = '{8'hFF, 8'h05, 8'h00, 8'h00};
    vecs[9]  = '{8'hFF, 8'h05, 8'h00, 8'h00};
    vecs[10] = '{8'hFF, 8'h05, 8'h00, 8'h00};
    vecs[11] = '{8'hFF, 8'h05, 8'h00, 8'h00};
    vecs[12] = '{8'hFF, 8'h05, 8'h00, 8'h00};
    vecs[13] = '{8'hFF, 8'hFF, 8'hFA, 8'h00};
    vecs[14] = '{8'hFF, 8'hFF, 8'h00, 8'h00};
    vecs[15] = '{8'h0F, 8'hFF, 8'h00, 8'h00};
    vecs[16] = '{8'h0F, 8'hFF, 8'h00, 8'h00};
    vecs[17] = '{8'h0F, 8'hFF, 8'h00, 8'h00};
    vecs[18] = '{8'h0F, 8'hFF, 8'h00, 8'h00};
    vecs[19] = '{8'h0F, 8'hFF, 8'h00, 8'h00};
    vecs[20] = '{8'h0F, 8'h0F, 8'h00, 8'hF0};
    vecs[21] = '{8'h0F, 8'h0F, 8'h00, 8'h00};

    // Power-on reset.
    #1;
    rst = 1'b1;
    #2;
    checkOutput("reset", 8'h00, 8'h00, 8'h00);
    checkFast("reset", 8'h00, 8'h00, 8'h00);
    releaseReset();

    // Idle switches after reset: nothing moves, no pulses.
    for (int i = 0; i < 20; i++) begin
      applyStimulus(8'h00);
      checkOutput($sformatf("idle[%0d]", i), 8'h00, 8'h00, 8'h00);
    end

    // Table-driven steps.
    for (int i = 0; i < 22; i++) begin
      applyStimulus(vecs[i].sw);
      checkOutput($sformatf("vec[%0d]", i), vecs[i].expStable,
                  vecs[i].expRise, vecs[i].expFall);
    end

    // Asynchronous reset clears a non-zero stable value at once.
    rst = 1'b1;
    #1;
    checkOutput("async reset", 8'h00, 8'h00, 8'h00);
    swIn = 8'h00;
    releaseReset();

    // Bit 0 bounces 1,0,1,0 then settles high: one-cycle pulses never
    // accumulate, the commit lands 6 edges after the final 0->1.
    begin
      logic [W-1:0] bounce [4];
      bounce = '{8'h01, 8'h00, 8'h01, 8'h00};
      for (int i = 0; i < 4; i++) begin
        applyStimulus(bounce[i]);
        checkOutput($sformatf("bounce[%0d]", i), 8'h00, 8'h00, 8'h00);
      end
    end
    for (int j = 0; j < 8; j++) begin
      applyStimulus(8'h01);
      checkOutput($sformatf("settle[%0d]", j),
                  (j >= 5) ? 8'h01 : 8'h00,
                  (j == 5) ? 8'h01 : 8'h00,
                  8'h00);
    end

    // Bit 3 goes high; reset hits while it is mid-count.
    for (int j = 0; j < 3; j++) begin
      applyStimulus(8'h09);
      checkOutput($sformatf("midcount[%0d]", j), 8'h01, 8'h00, 8'h00);
    end
    #2;
    rst = 1'b1;
    #1;
    checkOutput("midcount reset", 8'h00, 8'h00, 8'h00);
    @(posedge clk);
    #1;
    checkOutput("held reset", 8'h00, 8'h00, 8'h00);
    #2;
    rst = 1'b0;

    // Switches held high through reset come back as fresh rises.
    for (int j = 0; j < 7; j++) begin
      applyStimulus(8'h09);
      checkOutput($sformatf("post reset[%0d]", j),
                  (j >= 5) ? 8'h09 : 8'h00,
                  (j == 5) ? 8'h09 : 8'h00,
                  8'h00);
    end

    // Shortest debounce length: 3 edges to commit in each direction.
    rst = 1'b1;
    #1;
    checkFast("fast reset", 8'h00, 8'h00, 8'h00);
    swIn = 8'h00;
    releaseReset();
    for (int j = 0; j < 4; j++) begin
      applyStimulus(8'h80);
      checkFast($sformatf("fast rise[%0d]", j),
                (j >= 2) ? 8'h80 : 8'h00,
                (j == 2) ? 8'h80 : 8'h00,
                8'h00);
    end
    for (int j = 0; j < 4; j++) begin
      applyStimulus(8'h00);
      checkFast($sformatf("fast fall[%0d]", j),
                (j >= 2) ? 8'h00 : 8'h80,
                8'h00,
                (j == 2) ? 8'h80 : 8'h00);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             nCompared, nMismatched);
    $finish;
  end

endmodule
